// File: rtl/tree_fanout_pkg.sv
// Shared types and limits for the tree fan-out node.
package tree_fanout_pkg;

  localparam int TFN_MAX_CHILDREN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BCAST = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } tfn_state_e;

endpackage

// File: rtl/tree_fanout_timer.sv
// Saturating cycle counter with clear/enable. It raises expired in the cycle
// where the count of enabled cycles (including the current one) reaches the
// limit. A limit of 0 means the timer never expires.
module tree_fanout_timer #(
  parameter int TMO_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [TMO_W-1:0] limit,
  output logic             expired
);

  logic [TMO_W-1:0] count;
  logic [TMO_W-1:0] count_inc;

  // Saturating increment; the counter sticks at all-ones instead of wrapping.
  always_comb begin
    count_inc = (count == {TMO_W{1'b1}}) ? count : count + 1'b1;
    expired   = enable && (limit != '0) && (count_inc == limit);
  end

  // Counter register: clear has priority over counting.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count_inc;
    end
  end

endmodule

// File: rtl/tree_fanout_node.sv
// Hierarchy node: accepts one parent command, broadcasts it to the enabled
// children with independent handshakes, collects done/error pulses and
// returns one aggregated response, optionally cut short by a timeout.
module tree_fanout_node
  import tree_fanout_pkg::*;
#(
  parameter int NUM_CHILDREN = 5,
  parameter int DATA_W       = 16,
  parameter int TMO_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CHILDREN-1:0] cfg_enable_mask,
  input  logic [TMO_W-1:0]        cfg_timeout,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [DATA_W-1:0]       req_data,
  output logic [NUM_CHILDREN-1:0] ch_valid,
  input  logic [NUM_CHILDREN-1:0] ch_ready,
  output logic [DATA_W-1:0]       ch_data,
  input  logic [NUM_CHILDREN-1:0] ch_done,
  input  logic [NUM_CHILDREN-1:0] ch_err,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [NUM_CHILDREN-1:0] resp_done_mask,
  output logic [NUM_CHILDREN-1:0] resp_err_mask,
  output logic                    resp_timeout,
  output logic                    busy
);

  if (NUM_CHILDREN < 1 || NUM_CHILDREN > TFN_MAX_CHILDREN) begin : g_bad_children
    $error("tree_fanout_node: NUM_CHILDREN out of range 1..32");
  end

  tfn_state_e state_q, state_d;

  logic [NUM_CHILDREN-1:0] mask_q, mask_d;   // children in this command
  logic [NUM_CHILDREN-1:0] pend_q, pend_d;   // broadcast not yet accepted
  logic [NUM_CHILDREN-1:0] acc_q,  acc_d;    // broadcast accepted
  logic [NUM_CHILDREN-1:0] done_q, done_d;
  logic [NUM_CHILDREN-1:0] err_q,  err_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic [TMO_W-1:0]        limit_q, limit_d; // timeout frozen at acceptance
  logic                    tmo_q, tmo_d;
  logic                    req_ready_q, resp_valid_q, busy_q;
  logic                    tmr_clear, tmr_enable, tmr_expired;

  tree_fanout_timer #(.TMO_W(TMO_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .limit   (limit_q),
    .expired (tmr_expired)
  );

  // Next-state and datapath update for the whole transaction.
  // NOTE: every signal gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    mask_d     = mask_q;
    pend_d     = pend_q;
    acc_d      = acc_q;
    done_d     = done_q;
    err_d      = err_q;
    data_d     = data_q;
    limit_d    = limit_q;
    tmo_d      = tmo_q;
    tmr_clear  = 1'b0;
    tmr_enable = 1'b0;

    unique case (state_q)
      IDLE: begin
        // req_ready is high throughout IDLE, so req_valid alone is a handshake.
        if (req_valid) begin
          data_d    = req_data;
          mask_d    = cfg_enable_mask;
          pend_d    = cfg_enable_mask;
          acc_d     = '0;
          done_d    = '0;
          err_d     = '0;
          tmo_d     = 1'b0;
          limit_d   = cfg_timeout;
          tmr_clear = 1'b1;
          state_d   = (cfg_enable_mask == '0) ? RESP : BCAST;
        end
      end

      BCAST, WAIT: begin
        tmr_enable = 1'b1;
        // Only children whose broadcast was already accepted may complete.
        done_d = done_q | (ch_done & acc_q);
        err_d  = err_q  | (ch_done & ch_err & acc_q);
        if (state_q == BCAST) begin
          pend_d = pend_q & ~ch_ready;
          acc_d  = acc_q | (pend_q & ch_ready);
          if (pend_d == '0) state_d = WAIT;
        end else if (done_d == mask_q) begin
          state_d = RESP;
        end
        // Timeout wins over normal completion but keeps this cycle's dones.
        if (tmr_expired) begin
          pend_d  = '0;
          tmo_d   = 1'b1;
          state_d = RESP;
        end
      end

      RESP: begin
        if (resp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; handshake flags are registered decodes of
  // the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mask_q       <= '0;
      pend_q       <= '0;
      acc_q        <= '0;
      done_q       <= '0;
      err_q        <= '0;
      data_q       <= '0;
      limit_q      <= '0;
      tmo_q        <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      pend_q       <= pend_d;
      acc_q        <= acc_d;
      done_q       <= done_d;
      err_q        <= err_d;
      data_q       <= data_d;
      limit_q      <= limit_d;
      tmo_q        <= tmo_d;
      req_ready_q  <= (state_d == IDLE);
      resp_valid_q <= (state_d == RESP);
      busy_q       <= (state_d != IDLE);
    end
  end

  assign req_ready      = req_ready_q;
  assign busy           = busy_q;
  assign ch_valid       = pend_q;
  assign ch_data        = data_q;
  assign resp_valid     = resp_valid_q;
  assign resp_done_mask = done_q;
  assign resp_err_mask  = err_q;
  assign resp_timeout   = tmo_q;

endmodule

// File: tb/tb_tree_fanout_node.sv
// Self-checking bench for tree_fanout_node. Each transaction is described as
// a per-child schedule (ready delay, done/err pulses per cycle); a reference
// model derives the response cycle and masks from that schedule.
module tb_tree_fanout_node;

  localparam int NC   = 5;
  localparam int DW   = 16;
  localparam int TW   = 8;
  localparam int MAXC = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NC-1:0] cfg_enable_mask;
  logic [TW-1:0] cfg_timeout;
  logic          req_valid, req_ready;
  logic [DW-1:0] req_data;
  logic [NC-1:0] ch_valid, ch_ready, ch_done, ch_err;
  logic [DW-1:0] ch_data;
  logic          resp_valid, resp_ready;
  logic [NC-1:0] resp_done_mask, resp_err_mask;
  logic          resp_timeout, busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tree_fanout_node #(.NUM_CHILDREN(NC), .DATA_W(DW), .TMO_W(TW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_enable_mask(cfg_enable_mask), .cfg_timeout(cfg_timeout),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
    .ch_done(ch_done), .ch_err(ch_err),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_done_mask(resp_done_mask), .resp_err_mask(resp_err_mask),
    .resp_timeout(resp_timeout), .busy(busy)
  );

  // Scenario: cycle 0 is the acceptance cycle.
  logic [NC-1:0] sc_mask;
  int            sc_tmo;
  int            sc_rdy [NC];          // ready rises at cycle 1+sc_rdy
  bit            sc_pulse[NC][MAXC];
  bit            sc_perr [NC][MAXC];
  int            sc_hold;              // cycles resp_ready is held low
  int            sc_abort;             // cycle to pull rst_n, 0 = none

  // Model results.
  int            exp_end;              // last active cycle; resp_valid at +1
  logic [NC-1:0] exp_done, exp_err;
  logic          exp_tmo;

  // Observed response.
  int            obs_cycle;
  logic [NC-1:0] obs_done, obs_err;
  logic          obs_tmo;

  task automatic clear_scenario();
    sc_mask = '0; sc_tmo = 0; sc_hold = 0; sc_abort = 0;
    for (int i = 0; i < NC; i++) begin
      sc_rdy[i] = 0;
      for (int k = 0; k < MAXC; k++) begin
        sc_pulse[i][k] = 1'b0;
        sc_perr[i][k]  = 1'b0;
      end
    end
  endtask

  // A child completes on its first pulse after the cycle its command was taken.
  // The node finishes once the last child is accepted and all have completed,
  // unless the timeout cycle arrives first (or simultaneously).
  task automatic model();
    int  fv[NC];
    int  b, f;
    bit  all_done;
    exp_done = '0; exp_err = '0; exp_tmo = 1'b0;
    if (sc_mask == '0) begin
      exp_end = 0;
      return;
    end
    b = 0; f = 0; all_done = 1'b1;
    for (int i = 0; i < NC; i++) begin
      fv[i] = 0;
      if (sc_mask[i]) begin
        if (1 + sc_rdy[i] > b) b = 1 + sc_rdy[i];
        for (int k = 2 + sc_rdy[i]; k < MAXC; k++)
          if (sc_pulse[i][k] && fv[i] == 0) fv[i] = k;
        if (fv[i] == 0) all_done = 1'b0;
        else if (fv[i] > f) f = fv[i];
      end
    end
    if (b + 1 > f) f = b + 1;
    if (sc_tmo != 0 && (!all_done || sc_tmo <= f)) begin
      exp_end = sc_tmo;
      exp_tmo = 1'b1;
    end else if (all_done) begin
      exp_end = f;
    end else begin
      exp_end = 1000;
    end
    for (int i = 0; i < NC; i++) begin
      if (sc_mask[i] && fv[i] != 0 && fv[i] <= exp_end) exp_done[i] = 1'b1;
      if (sc_mask[i])
        for (int k = 2 + sc_rdy[i]; k <= exp_end && k < MAXC; k++)
          if (sc_pulse[i][k] && sc_perr[i][k]) exp_err[i] = 1'b1;
    end
  endtask

  task automatic drive_cycle(input int k);
    for (int i = 0; i < NC; i++) begin
      ch_ready[i] = (k >= 1 + sc_rdy[i]);
      ch_done[i]  = (k < MAXC) ? sc_pulse[i][k] : 1'b0;
      ch_err[i]   = (k < MAXC) ? sc_perr[i][k]  : 1'b0;
    end
  endtask

  task automatic hard_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; resp_ready = 1'b0;
    ch_ready = '0; ch_done = '0; ch_err = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Entered just after a rising edge; returns just after a rising edge.
  task automatic run_txn(input logic [DW-1:0] data);
    logic [NC-1:0] exp_cv;
    logic          exp_rv;
    bit            seen;
    model();
    obs_cycle = -1; obs_done = 'x; obs_err = 'x; obs_tmo = 1'bx;
    cfg_enable_mask = sc_mask;
    cfg_timeout     = TW'(sc_tmo);
    req_data        = data;
    req_valid       = 1'b1;
    resp_ready      = 1'b0;
    drive_cycle(0);
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0)
      $display("FAIL idle_ready: req_ready=%b busy=%b resp_valid=%b want 1 0 0",
               req_ready, busy, resp_valid);
    if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) errors++;
    @(posedge clk); #1;
    // Scramble inputs that must have been captured at acceptance.
    req_valid       = 1'b0;
    req_data        = DW'($urandom);
    cfg_enable_mask = NC'($urandom);
    cfg_timeout     = TW'($urandom_range(1, 3));
    seen = 1'b0;
    for (int k = 1; k < MAXC && !seen; k++) begin
      drive_cycle(k);
      if (k == sc_abort) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || ch_valid !== '0 || req_ready !== 1'b1 ||
            resp_done_mask !== '0 || resp_err_mask !== '0 || resp_timeout !== 1'b0 || ch_data !== '0) begin
          errors++;
          $display("FAIL async_reset: busy=%b resp_valid=%b ch_valid=%b req_ready=%b done=%b err=%b tmo=%b data=%h want all reset",
                   busy, resp_valid, ch_valid, req_ready, resp_done_mask, resp_err_mask, resp_timeout, ch_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ch_ready = '0; ch_done = '0; ch_err = '0;
        repeat (3) begin
          @(negedge clk);
          checks++;
          if (resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL no_resp_after_abort: resp_valid=%b busy=%b want 0 0", resp_valid, busy);
          end
        end
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
      for (int i = 0; i < NC; i++)
        exp_cv[i] = sc_mask[i] && (k <= 1 + sc_rdy[i]) && (k <= exp_end);
      exp_rv = (k == exp_end + 1);
      checks++;
      if (ch_valid !== exp_cv) begin
        errors++;
        $display("FAIL ch_valid@%0d: got %b want %b", k, ch_valid, exp_cv);
      end
      checks++;
      if (resp_valid !== exp_rv) begin
        errors++;
        $display("FAIL resp_valid@%0d: got %b want %b", k, resp_valid, exp_rv);
      end
      if (k == 1) begin
        checks++;
        if (ch_data !== data) begin
          errors++;
          $display("FAIL ch_data: got %h want %h", ch_data, data);
        end
      end
      if (resp_valid === 1'b1) begin
        seen = 1'b1;
        obs_cycle = k; obs_done = resp_done_mask; obs_err = resp_err_mask; obs_tmo = resp_timeout;
      end else begin
        checks++;
        if (busy !== 1'b1 || req_ready !== 1'b0) begin
          errors++;
          $display("FAIL busy@%0d: busy=%b req_ready=%b want 1 0", k, busy, req_ready);
        end
        @(posedge clk); #1;
      end
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL resp_budget: no resp_valid within %0d cycles, want cycle %0d", MAXC, exp_end + 1);
      hard_reset();
      return;
    end
    checks++;
    if (obs_done !== exp_done || obs_err !== exp_err || obs_tmo !== exp_tmo) begin
      errors++;
      $display("FAIL resp_fields: done=%b err=%b tmo=%b want %b %b %b",
               obs_done, obs_err, obs_tmo, exp_done, exp_err, exp_tmo);
    end
    // Hold back-pressure while children keep pulsing; the response must not move.
    for (int h = 0; h < sc_hold; h++) begin
      @(posedge clk); #1;
      ch_done = '1; ch_err = '1;
      @(negedge clk);
      checks++;
      if (resp_valid !== 1'b1 || resp_done_mask !== exp_done || resp_err_mask !== exp_err ||
          resp_timeout !== exp_tmo) begin
        errors++;
        $display("FAIL resp_hold%0d: valid=%b done=%b err=%b tmo=%b want 1 %b %b %b",
                 h, resp_valid, resp_done_mask, resp_err_mask, resp_timeout, exp_done, exp_err, exp_tmo);
      end
    end
    @(posedge clk); #1;
    ch_done = '0; ch_err = '0; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_data = '0; resp_ready = 1'b0;
    cfg_enable_mask = '0; cfg_timeout = '0;
    ch_ready = '0; ch_done = '0; ch_err = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || ch_valid !== '0 || resp_done_mask !== '0 ||
        resp_err_mask !== '0 || resp_timeout !== 1'b0 || ch_data !== '0 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_values: busy=%b rv=%b cv=%b dm=%b em=%b tmo=%b data=%h rr=%b",
               busy, resp_valid, ch_valid, resp_done_mask, resp_err_mask, resp_timeout, ch_data, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_resp(input string name, input int cyc, input logic [NC-1:0] dm,
                            input logic [NC-1:0] em, input logic tmo);
    checks++;
    if (obs_cycle != cyc || obs_done !== dm || obs_err !== em || obs_tmo !== tmo) begin
      errors++;
      $display("FAIL %s: cycle=%0d done=%b err=%b tmo=%b want %0d %b %b %b",
               name, obs_cycle, obs_done, obs_err, obs_tmo, cyc, dm, em, tmo);
    end
  endtask

  task automatic full_scenario();
    clear_scenario();
    sc_mask = 5'b11111;
    for (int i = 0; i < NC; i++) sc_pulse[i][2] = 1'b1;
  endtask

  task automatic test_full_fanout();
    full_scenario();
    run_txn(16'hA5C3);
    check_resp("full_fanout", 3, 5'b11111, 5'b00000, 1'b0);
  endtask

  task automatic test_partial_mask();
    clear_scenario();
    sc_mask = 5'b10101;
    sc_rdy[2] = 4;
    sc_pulse[0][3] = 1'b1;
    sc_pulse[2][7] = 1'b1;
    sc_pulse[4][3] = 1'b1; sc_perr[4][3] = 1'b1;
    run_txn(16'h1234);
    check_resp("partial_mask", 8, 5'b10101, 5'b10000, 1'b0);
  endtask

  task automatic test_zero_mask();
    clear_scenario();
    for (int i = 0; i < NC; i++) begin
      sc_pulse[i][1] = 1'b1; sc_perr[i][1] = 1'b1;
    end
    run_txn(16'h0F0F);
    check_resp("zero_mask", 1, 5'b00000, 5'b00000, 1'b0);
  endtask

  task automatic test_timeout();
    clear_scenario();
    sc_mask = 5'b11111; sc_tmo = 10;
    for (int i = 0; i < NC; i++) if (i != 3) sc_pulse[i][3] = 1'b1;
    run_txn(16'hBEEF);
    check_resp("timeout", 11, 5'b10111, 5'b00000, 1'b1);
  endtask

  task automatic test_timeout_with_done();
    clear_scenario();
    sc_mask = 5'b00011; sc_tmo = 6;
    sc_pulse[0][3] = 1'b1;
    sc_pulse[1][6] = 1'b1; sc_perr[1][6] = 1'b1;
    run_txn(16'h0600);
    check_resp("timeout_same_cycle_done", 7, 5'b00011, 5'b00010, 1'b1);
  endtask

  task automatic test_ignored_done();
    clear_scenario();
    sc_mask = 5'b01011; sc_rdy[1] = 3; sc_hold = 5;
    sc_pulse[0][3] = 1'b1;
    sc_pulse[3][3] = 1'b1;
    sc_pulse[2][3] = 1'b1; sc_perr[2][3] = 1'b1;   // disabled child
    sc_pulse[1][2] = 1'b1; sc_perr[1][2] = 1'b1;   // before acceptance
    sc_pulse[1][4] = 1'b1; sc_perr[1][4] = 1'b1;   // in the acceptance cycle
    sc_pulse[1][6] = 1'b1;
    run_txn(16'h5A5A);
    check_resp("ignored_done", 7, 5'b01011, 5'b00000, 1'b0);
  endtask

  task automatic test_reset_mid();
    clear_scenario();
    sc_mask = 5'b00011; sc_abort = 4;
    sc_pulse[0][2] = 1'b1;
    run_txn(16'hDEAD);
    full_scenario();
    run_txn(16'h7777);
    check_resp("after_reset", 3, 5'b11111, 5'b00000, 1'b0);
  endtask

  task automatic test_random();
    int p;
    logic e;
    for (int n = 0; n < 30; n++) begin
      clear_scenario();
      sc_mask = NC'($urandom);
      sc_tmo  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0;
      sc_hold = $urandom_range(0, 3);
      for (int i = 0; i < NC; i++) begin
        sc_rdy[i] = $urandom_range(0, 4);
        if ($urandom_range(0, 3) == 0) begin
          p = $urandom_range(0, 1 + sc_rdy[i]);
          sc_pulse[i][p] = 1'b1; sc_perr[i][p] = 1'b1;
        end
        if (sc_tmo == 0 || $urandom_range(0, 4) != 0) begin
          p = 2 + sc_rdy[i] + $urandom_range(0, 12);
          e = 1'($urandom_range(0, 1));
          sc_pulse[i][p] = 1'b1; sc_perr[i][p] = e;
          if ($urandom_range(0, 2) == 0) begin
            sc_pulse[i][p+1] = 1'b1; sc_perr[i][p+1] = e;
          end
        end
      end
      run_txn(DW'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_full_fanout();
    test_partial_mask();
    test_zero_mask();
    test_timeout();
    test_timeout_with_done();
    test_ignored_done();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tree_fanout_node.md
# tree_fanout_node

Parametrised hierarchy node controller that sits between one parent and `NUM_CHILDREN` child blocks in the generated module tree. It accepts one command from the parent and broadcasts it to every enabled child with per-child valid/ready handshakes. It then collects per-child completion and error pulses and returns one aggregated response to the parent, with an optional timeout. It succeeds fixed, port-less fan-out nodes and adds a runtime child-enable mask, independent child back-pressure and timeout reporting.

## Interface
- `NUM_CHILDREN`, default 5: number of child channels (1..32).
- `DATA_W`, default 16: command payload width.
- `TMO_W`, default 8: timeout counter width.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `cfg_enable_mask`  in  NUM_CHILDREN  children that take part in the next command.
- `cfg_timeout`  in  TMO_W  cycle limit for BCAST+WAIT; 0 disables the timeout.
- `req_valid` / `req_ready`  in / out  1  parent command handshake.
- `req_data`  in  DATA_W  command payload.
- `ch_valid`  out  NUM_CHILDREN  per-child command valid.
- `ch_ready`  in  NUM_CHILDREN  per-child command ready.
- `ch_data`  out  DATA_W  latched payload, shared by all children.
- `ch_done`  in  NUM_CHILDREN  per-child completion pulse.
- `ch_err`  in  NUM_CHILDREN  error qualifier, sampled with `ch_done`.
- `resp_valid` / `resp_ready`  out / in  1  response handshake.
- `resp_done_mask`  out  NUM_CHILDREN  children that completed.
- `resp_err_mask`  out  NUM_CHILDREN  children that completed with error.
- `resp_timeout`  out  1  response was forced by timeout.
- `busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, BCAST, WAIT, RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid && req_ready`: latch `req_data` into `ch_data`, `mask` = `cfg_enable_mask`, `pend` = `mask`. Clear `acc`, `done`, `err` and the timer.
  - Next state is BCAST. If `mask`==0, next state is RESP with empty masks.
- **BCAST**
  - `ch_valid` = `pend`.
  - On `ch_valid[i] && ch_ready[i]`: clear `pend[i]`, set `acc[i]`.
  - Each child is independent; `ch_valid[i]` stays high until accepted.
  - When `pend` becomes 0, go to WAIT.
- **Done capture (BCAST and WAIT)**
  - `done |= ch_done & acc`.
  - `err |= ch_done & ch_err & acc`.
  - Pulses from children not yet accepted, or not enabled, are ignored.
  - Duplicate pulses are idempotent.
- **WAIT**: when `done == mask`, go to RESP.
- **Timeout**
  - Timer counts every cycle in BCAST/WAIT.
  - If `cfg_timeout`≠0 and timer == `cfg_timeout`, go to RESP with `resp_timeout`=1. `pend` is cleared, so `ch_valid` drops.
  - Done in the same cycle as timeout: the done is captured first; `resp_timeout` is still set.
  - The timer saturates and never wraps.
- **RESP**
  - `resp_valid`=1; `resp_done_mask`=`done`, `resp_err_mask`=`err`, held stable until `resp_ready`.
  - Then go to IDLE.
  - `ch_done` pulses in RESP/IDLE are dropped.
- `cfg_*` changes during a transaction have no effect; they are sampled only at request acceptance.

## Timing
- Reset values: state IDLE; `ch_valid`, `resp_valid`, `resp_timeout`, `busy`, all masks = 0; `ch_data` = 0.
- `req_ready` is registered; it equals (state==IDLE).
- `ch_valid` and `resp_*` are registered outputs.
- Minimum latency:
  - Request accepted at cycle 0.
  - `ch_valid` high at cycle 1; all children ready at cycle 1.
  - WAIT at cycle 2; all `ch_done` at cycle 2.
  - `resp_valid` at cycle 3.
- Back-to-back: the earliest next `req_ready` is one cycle after the `resp_valid && resp_ready` cycle.
- Timeout response: `resp_valid` rises exactly `cfg_timeout`+1 cycles after acceptance.
- `rst_n` low mid-transaction: all outputs go to reset values immediately (asynchronous); no response is issued for the aborted command.

## Structure
- Package `tree_fanout_pkg`:
  - state enum `tfn_state_e` (IDLE, BCAST, WAIT, RESP);
  - constant `TFN_MAX_CHILDREN`=32, checked by an elaboration assertion on `NUM_CHILDREN`.
- Sub-module `tree_fanout_timer`: saturating TMO_W counter with clear, enable and `expired` output (compare against limit, 0 = never).

## Test plan
- `NUM_CHILDREN`=5, mask 5'b11111, all ready at cycle 1, all done at cycle 2 -> `resp_valid` at cycle 3, done_mask 5'b11111, err 0, timeout 0.
- Mask 5'b10101; child 2 ready 4 cycles late, child 4 errs on done -> only `ch_valid` bits 0, 2, 4 assert. Bit 2 is held until ready. Response done 5'b10101, err 5'b10000.
- Mask 0 -> no `ch_valid`; `resp_valid` one cycle after acceptance with empty masks.
- `cfg_timeout`=10, child 3 never sends done -> `resp_valid` 11 cycles after acceptance, timeout 1, done_mask missing bit 3.
- `ch_done` from a disabled child, and a done before that child's acceptance -> ignored in `resp_done_mask`. `resp_ready` held low 5 cycles -> response stable throughout.
- Assert `rst_n` low during WAIT -> `busy`, `resp_valid` and `ch_valid` are 0 immediately. After release, a fresh request completes normally.
